// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the unified-memory arbiter.
// Size encodings, ownership/state enums and burst-length decode.
package mem_arb_pkg;

    localparam logic [1:0] SZ_BYTE  = 2'd0;
    localparam logic [1:0] SZ_WORD  = 2'd1;
    localparam logic [1:0] SZ_4WORD = 2'd2;
    localparam logic [1:0] SZ_8WORD = 2'd3;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    function automatic logic [3:0] beats_for(input logic [1:0] size);
        case (size)
            SZ_4WORD: return 4'd4;
            SZ_8WORD: return 4'd8;
            default:  return 4'd1;
        endcase
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin picker: index 0 = instruction side, index 1 = data side.
// On a tie the side that was not granted last wins; i_update records the winner.
module rr_arb2 #(
    parameter bit DATA_FIRST = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] i_req,
    input  logic       i_update,
    output logic [1:0] o_gnt
);

    // 1 when the data side held the last grant
    logic r_last_d;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset)
            r_last_d <= !DATA_FIRST;
        else if (i_update)
            r_last_d <= o_gnt[1];
    end

    always_comb begin
        o_gnt = 2'b00;
        case (i_req)
            2'b01:   o_gnt = 2'b01;
            2'b10:   o_gnt = 2'b10;
            2'b11:   o_gnt = r_last_d ? 2'b01 : 2'b10;
            default: o_gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single-port unified memory between instruction fetch (read-only)
// and load/store (read/write), running 1/4/8-beat bursts one owner at a time.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter bit DATA_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    input  logic [1:0]  i_size,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,
    output logic        i_done,
    input  logic        d_req,
    input  logic [31:0] d_addr,
    input  logic [1:0]  d_size,
    input  logic        d_we,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_wready,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_done,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_data_in,
    output logic [1:0]  mem_access_size,
    output logic        mem_rd_wr,
    output logic        mem_enable,
    input  logic [31:0] mem_data_out,
    input  logic        mem_busy
);

    state_t      r_state;
    state_t      w_next_state;
    owner_t      r_owner;
    logic [31:0] r_addr;
    logic [1:0]  r_size;
    logic        r_rd;
    logic [2:0]  r_beat;
    logic        r_rvalid;

    logic        w_can_grant;
    logic [1:0]  w_gnt;
    logic        w_start;
    logic [1:0]  w_new_size;
    logic [2:0]  w_new_beat;
    logic        w_wr_beat;
    logic        w_last_rvalid;

    // Arbitration is frozen outside IDLE, while memory is busy, and during reset.
    assign w_can_grant = (r_state == IDLE) && !mem_busy && !reset;
    assign w_start     = |w_gnt;
    // Fetch treats byte size as a full word.
    assign w_new_size  = w_gnt[1] ? d_size : ((i_size == SZ_BYTE) ? SZ_WORD : i_size);
    assign w_new_beat  = 3'(beats_for(w_new_size) - 4'd1);

    rr_arb2 #(
        .DATA_FIRST (DATA_FIRST)
    ) u_rr_arb2 (
        .clk      (clk),
        .reset    (reset),
        .i_req    ({d_req, i_req} & {2{w_can_grant}}),
        .i_update (w_start),
        .o_gnt    (w_gnt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_owner  <= OWN_I;
            r_addr   <= '0;
            r_size   <= '0;
            r_rd     <= 1'b0;
            r_beat   <= '0;
            r_rvalid <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            // Memory registers read data, so each read beat returns one cycle later.
            r_rvalid <= (r_state == ACCESS) && r_rd;
            if (w_start) begin
                r_owner <= w_gnt[1] ? OWN_D : OWN_I;
                r_addr  <= w_gnt[1] ? d_addr : i_addr;
                r_size  <= w_new_size;
                r_rd    <= w_gnt[1] ? !d_we : 1'b1;
                r_beat  <= w_new_beat;
            end else if ((r_state == ACCESS) && (r_beat != 3'd0)) begin
                r_beat <= r_beat - 3'd1;
            end
        end
    end

    assign w_wr_beat     = (r_state == ACCESS) && !r_rd;
    assign w_last_rvalid = r_rvalid && (r_state == RESP);

    // NOTE: every output gets a default first so no path through the block infers a latch.
    always_comb begin
        w_next_state    = r_state;
        i_gnt           = 1'b0;
        d_gnt           = 1'b0;
        i_rvalid        = 1'b0;
        i_rdata         = '0;
        i_done          = 1'b0;
        d_wready        = 1'b0;
        d_rvalid        = 1'b0;
        d_rdata         = '0;
        d_done          = 1'b0;
        mem_enable      = 1'b0;
        mem_data_in     = '0;
        mem_addr        = r_addr;
        mem_access_size = r_size;
        mem_rd_wr       = r_rd;

        case (r_state)
            IDLE: begin
                i_gnt = w_gnt[0];
                d_gnt = w_gnt[1];
                if (w_start)
                    w_next_state = ACCESS;
            end
            ACCESS: begin
                mem_enable = 1'b1;
                if (r_beat == 3'd0)
                    w_next_state = r_rd ? RESP : IDLE;
            end
            RESP:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase

        if (w_wr_beat) begin
            d_wready    = 1'b1;
            mem_data_in = d_wdata;
            d_done      = (r_beat == 3'd0);
        end

        if (r_rvalid && (r_owner == OWN_I)) begin
            i_rvalid = 1'b1;
            i_rdata  = mem_data_out;
            i_done   = w_last_rvalid;
        end
        if (r_rvalid && (r_owner == OWN_D)) begin
            d_rvalid = 1'b1;
            d_rdata  = (r_size == SZ_BYTE) ? {24'b0, mem_data_out[7:0]} : mem_data_out;
            d_done   = w_last_rvalid;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a behavioural registered memory plus a queue of
// expected read beats that is filled at grant time and drained on each rvalid.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic [1:0]  i_size = '0;
    logic        i_gnt, i_rvalid, i_done;
    logic [31:0] i_rdata;
    logic        d_req = 1'b0;
    logic [31:0] d_addr = '0;
    logic [1:0]  d_size = '0;
    logic        d_we = 1'b0;
    logic [31:0] d_wdata = '0;
    logic        d_gnt, d_wready, d_rvalid, d_done;
    logic [31:0] d_rdata;
    logic [31:0] mem_addr, mem_data_in;
    logic [1:0]  mem_access_size;
    logic        mem_rd_wr, mem_enable;
    logic [31:0] mem_data_out = '0;
    logic        mem_busy = 1'b0;

    typedef struct packed {
        logic        own;
        logic [31:0] data;
        logic        last;
    } exp_t;

    exp_t exp_q[$];
    int   n_assert = 0;
    int   n_fail = 0;
    int   mem_beat = 0;

    mem_arbiter #(.DATA_FIRST(1'b1)) dut (
        .clk             (clk),
        .reset           (reset),
        .i_req           (i_req),
        .i_addr          (i_addr),
        .i_size          (i_size),
        .i_gnt           (i_gnt),
        .i_rvalid        (i_rvalid),
        .i_rdata         (i_rdata),
        .i_done          (i_done),
        .d_req           (d_req),
        .d_addr          (d_addr),
        .d_size          (d_size),
        .d_we            (d_we),
        .d_wdata         (d_wdata),
        .d_gnt           (d_gnt),
        .d_wready        (d_wready),
        .d_rvalid        (d_rvalid),
        .d_rdata         (d_rdata),
        .d_done          (d_done),
        .mem_addr        (mem_addr),
        .mem_data_in     (mem_data_in),
        .mem_access_size (mem_access_size),
        .mem_rd_wr       (mem_rd_wr),
        .mem_enable      (mem_enable),
        .mem_data_out    (mem_data_out),
        .mem_busy        (mem_busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_fn(input logic [31:0] a, input int k);
        return (a + 32'(k) * 32'd4) ^ 32'h5A5A_1234;
    endfunction

    function automatic logic [31:0] wpat(input int k);
        return 32'hC0DE_0000 + 32'(k) * 32'h0000_1111;
    endfunction

    // Registered memory: data for an enabled read cycle appears after the next edge.
    always @(posedge clk) begin
        if (mem_enable && mem_rd_wr) begin
            mem_data_out <= mem_fn(mem_addr, mem_beat);
            mem_beat     <= mem_beat + 1;
        end else begin
            mem_data_out <= 32'hDEAD_BEEF;
            mem_beat     <= 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_read(input logic own, input logic [31:0] addr, input logic [1:0] size);
        int   n;
        exp_t e;
        n = (size == SZ_4WORD) ? 4 : (size == SZ_8WORD) ? 8 : 1;
        for (int k = 0; k < n; k++) begin
            e.own  = own;
            e.data = mem_fn(addr, k);
            if (own && size == SZ_BYTE)
                e.data = {24'b0, e.data[7:0]};
            e.last = (k == n - 1);
            exp_q.push_back(e);
        end
    endtask

    // Advance one clock, sample 1 time unit after the edge, and score any read beat.
    task automatic cyc();
        @(posedge clk);
        #1;
        if (i_rvalid || d_rvalid) begin
            exp_t e;
            check("one_rvalid", {31'b0, i_rvalid && d_rvalid}, 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_rvalid", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("rvalid_owner", {31'b0, d_rvalid}, {31'b0, e.own});
                check("rdata", e.own ? d_rdata : i_rdata, e.data);
                check("rdone", {31'b0, e.own ? d_done : i_done}, {31'b0, e.last});
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        i_req = 1'b0;
        d_req = 1'b0;
        d_we  = 1'b0;
        repeat (2) cyc();
        check("reset_ctrl", {20'b0, i_gnt, i_rvalid, i_done, d_gnt, d_wready, d_rvalid,
                             d_done, mem_rd_wr, mem_enable, mem_access_size, 1'b0}, 32'd0);
        check("reset_addr", mem_addr, 32'd0);
        check("reset_rdata", i_rdata | d_rdata | mem_data_in, 32'd0);
        exp_q.delete();
        reset = 1'b0;
        cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic exp_own;
        int   waited;

        do_reset();

        // Single-word fetch: gnt@T, enable@T+1, rvalid+done@T+2.
        i_req = 1'b1; i_addr = 32'h8002_0000; i_size = SZ_WORD;
        #1;
        check("t1_i_gnt", {31'b0, i_gnt}, 32'd1);
        check("t1_d_gnt", {31'b0, d_gnt}, 32'd0);
        push_read(1'b0, 32'h8002_0000, SZ_WORD);
        cyc();
        i_req = 1'b0;
        check("t1_enable", {31'b0, mem_enable}, 32'd1);
        check("t1_addr", mem_addr, 32'h8002_0000);
        check("t1_size_rd", {29'b0, mem_access_size, mem_rd_wr}, {29'b0, SZ_WORD, 1'b1});
        check("t1_no_early_rvalid", {31'b0, i_rvalid}, 32'd0);
        cyc();
        check("t1_enable_off", {31'b0, mem_enable}, 32'd0);
        cyc();
        check("t1_drained", 32'(exp_q.size()), 32'd0);

        // First tie after reset goes to D; I waits until D's burst completes.
        do_reset();
        i_req = 1'b1; i_addr = 32'h8002_0040; i_size = SZ_WORD;
        d_req = 1'b1; d_addr = 32'h0000_1000; d_size = SZ_4WORD; d_we = 1'b0;
        #1;
        check("t2_d_gnt", {31'b0, d_gnt}, 32'd1);
        check("t2_i_gnt", {31'b0, i_gnt}, 32'd0);
        push_read(1'b1, 32'h0000_1000, SZ_4WORD);
        cyc();
        d_req = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            check("t2_enable", {31'b0, mem_enable}, {31'b0, k <= 4});
            check("t2_i_wait", {31'b0, i_gnt}, 32'd0);
            cyc();
        end
        check("t2_d_drained", 32'(exp_q.size()), 32'd0);
        check("t2_i_gnt_t6", {31'b0, i_gnt}, 32'd1);
        push_read(1'b0, 32'h8002_0040, SZ_WORD);
        cyc();
        i_req = 1'b0;
        repeat (3) cyc();
        check("t2_i_drained", 32'(exp_q.size()), 32'd0);

        // 8-beat write: enable and wready for 8 consecutive cycles, done on the 8th.
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_2000; d_size = SZ_8WORD; d_wdata = wpat(0);
        #1;
        check("t3_d_gnt", {31'b0, d_gnt}, 32'd1);
        cyc();
        d_req = 1'b0;
        for (int k = 0; k < 8; k++) begin
            check("t3_enable", {31'b0, mem_enable}, 32'd1);
            check("t3_wready", {31'b0, d_wready}, 32'd1);
            check("t3_wdata", mem_data_in, wpat(k));
            check("t3_rd_wr", {31'b0, mem_rd_wr}, 32'd0);
            check("t3_done", {31'b0, d_done}, {31'b0, k == 7});
            d_wdata = wpat(k + 1);
            cyc();
        end
        check("t3_after", {29'b0, mem_enable, d_wready, d_done}, 32'd0);
        check("t3_data_in_idle", mem_data_in, 32'd0);
        d_we = 1'b0;

        // Both held: D won last, so grants alternate starting with I.
        i_req = 1'b1; i_addr = 32'h0000_3000; i_size = SZ_WORD;
        d_req = 1'b1; d_addr = 32'h0000_4000; d_size = SZ_WORD; d_we = 1'b0;
        #1;
        exp_own = 1'b0;
        for (int g = 0; g < 4; g++) begin
            waited = 0;
            while (!(i_gnt || d_gnt) && waited < 10) begin
                cyc();
                waited++;
            end
            check("t4_grant_timeout", {31'b0, waited < 10}, 32'd1);
            check("t4_one_gnt", {31'b0, i_gnt && d_gnt}, 32'd0);
            check("t4_rr_owner", {31'b0, d_gnt}, {31'b0, exp_own});
            push_read(exp_own, exp_own ? 32'h0000_4000 : 32'h0000_3000, SZ_WORD);
            exp_own = !exp_own;
            cyc();
        end
        i_req = 1'b0;
        d_req = 1'b0;
        repeat (4) cyc();
        check("t4_drained", 32'(exp_q.size()), 32'd0);

        // Byte read at offset 2 returns a zero-extended byte.
        d_req = 1'b1; d_addr = 32'h0000_1002; d_size = SZ_BYTE; d_we = 1'b0;
        #1;
        check("t5_d_gnt", {31'b0, d_gnt}, 32'd1);
        push_read(1'b1, 32'h0000_1002, SZ_BYTE);
        cyc();
        d_req = 1'b0;
        check("t5_size", {30'b0, mem_access_size}, {30'b0, SZ_BYTE});
        repeat (3) cyc();
        check("t5_drained", 32'(exp_q.size()), 32'd0);

        // Busy memory blocks the grant until it clears.
        mem_busy = 1'b1;
        i_req = 1'b1; i_addr = 32'h8000_0100; i_size = SZ_BYTE;
        #1;
        check("t6_busy_no_gnt", {31'b0, i_gnt}, 32'd0);
        cyc();
        check("t6_busy_still", {30'b0, i_gnt, mem_enable}, 32'd0);
        mem_busy = 1'b0;
        #1;
        check("t6_gnt", {31'b0, i_gnt}, 32'd1);
        push_read(1'b0, 32'h8000_0100, SZ_WORD);
        cyc();
        i_req = 1'b0;
        check("t6_byte_as_word", {30'b0, mem_access_size}, {30'b0, SZ_WORD});
        repeat (3) cyc();
        check("t6_drained", 32'(exp_q.size()), 32'd0);

        // Reset during the 3rd beat of an 8-word read aborts cleanly.
        d_req = 1'b1; d_addr = 32'h0000_5000; d_size = SZ_8WORD; d_we = 1'b0;
        #1;
        check("t7_d_gnt", {31'b0, d_gnt}, 32'd1);
        push_read(1'b1, 32'h0000_5000, SZ_8WORD);
        cyc();
        d_req = 1'b0;
        repeat (2) cyc();
        check("t7_third_beat", {31'b0, mem_enable}, 32'd1);
        reset = 1'b1;
        cyc();
        check("t7_abort", {28'b0, mem_enable, d_rvalid, d_done, d_wready}, 32'd0);
        exp_q.delete();
        reset = 1'b0;
        cyc();
        check("t7_quiet", {29'b0, mem_enable, d_rvalid, d_done}, 32'd0);
        i_req = 1'b1; i_addr = 32'h8000_0200; i_size = SZ_WORD;
        #1;
        check("t7_new_gnt", {31'b0, i_gnt}, 32'd1);
        push_read(1'b0, 32'h8000_0200, SZ_WORD);
        cyc();
        i_req = 1'b0;
        repeat (3) cyc();
        check("t7_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
